// File: rtl/ysyx_lsu.sv
// ysyx_lsu - load/store stage between EXU and WBU.
//
// Accepts one EXU result per prev_valid/ready_o handshake. A legal memory
// instruction issues a single aligned word access on the data bus. The
// returned word is shifted down and sign- or zero-extended for loads. The
// result is then forwarded to WBU with a valid_o/next_ready handshake.
// Non-memory instructions reach WBU one cycle after accept. Misaligned or
// illegal accesses skip the bus and are flagged on misalign_o.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   pc, inst, ebreak, rd       EXU payload, captured on accept
//   alu_res                    EXU result / effective address
//   wdata, funct3              store data, access size/sign
//   mem_ren, mem_wen           load / store select
//   prev_valid, ready_o        upstream handshake
//   pc_o, inst_o, ebreak_o,
//   rd_o, wb_data_o,
//   misalign_o                 payload to WBU
//   valid_o, next_ready        downstream handshake
//   mem_req_*                  word request (addr, wen, wdata, wstrb)
//   mem_rsp_valid, mem_rdata   read data / write acknowledge
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready_o=1, waiting for an EXU payload
// REQ   | bus request asserted, waiting for mem_req_ready
// WAIT  | request taken, waiting for mem_rsp_valid
// DONE  | valid_o=1, holding payload until next_ready

module ysyx_lsu #(
    parameter int BIT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BIT_W-1:0]   pc,
    input  logic [BIT_W-1:0]   inst,
    input  logic               ebreak,
    input  logic [4:0]         rd,
    input  logic [BIT_W-1:0]   alu_res,
    input  logic [BIT_W-1:0]   wdata,
    input  logic [2:0]         funct3,
    input  logic               mem_ren,
    input  logic               mem_wen,
    input  logic               prev_valid,
    output logic               ready_o,
    output logic [BIT_W-1:0]   pc_o,
    output logic [BIT_W-1:0]   inst_o,
    output logic               ebreak_o,
    output logic [4:0]         rd_o,
    output logic [BIT_W-1:0]   wb_data_o,
    output logic               misalign_o,
    output logic               valid_o,
    input  logic               next_ready,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic               mem_req_wen,
    output logic [BIT_W-1:0]   mem_addr,
    output logic [BIT_W-1:0]   mem_wdata,
    output logic [BIT_W/8-1:0] mem_wstrb,
    input  logic               mem_rsp_valid,
    input  logic [BIT_W-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [1:0]        addr_lo;
    logic [2:0]        funct3_q;
    logic              is_load;

    logic              accept;
    logic              acc_mem;
    logic              acc_illegal;
    logic [BIT_W/8-1:0] acc_strb;
    logic [BIT_W-1:0]  acc_wdata;
    logic [BIT_W-1:0]  rsp_shift;
    logic [BIT_W-1:0]  load_data;

    assign accept = prev_valid & ready_o & (state == IDLE);
    assign acc_mem = mem_ren | mem_wen;

    // Legality of the incoming access, and the store lane placement.
    always_comb begin
        acc_illegal = 1'b0;
        acc_strb    = '0;
        acc_wdata   = wdata << {alu_res[1:0], 3'b000};
        if (mem_ren && mem_wen) begin
            acc_illegal = 1'b1;
        end else if (mem_ren) begin
            case (funct3)
                3'b000, 3'b100: acc_illegal = 1'b0;
                3'b001, 3'b101: acc_illegal = alu_res[0];
                3'b010:         acc_illegal = |alu_res[1:0];
                default:        acc_illegal = 1'b1;
            endcase
        end else if (mem_wen) begin
            case (funct3)
                3'b000: begin
                    acc_illegal = 1'b0;
                    acc_strb    = 4'b0001 << alu_res[1:0];
                end
                3'b001: begin
                    acc_illegal = alu_res[0];
                    acc_strb    = 4'b0011 << alu_res[1:0];
                end
                3'b010: begin
                    acc_illegal = |alu_res[1:0];
                    acc_strb    = 4'b1111;
                end
                default: acc_illegal = 1'b1;
            endcase
        end
    end

    // Load alignment uses the captured address offset and size.
    always_comb begin
        rsp_shift = mem_rdata >> {addr_lo, 3'b000};
        load_data = mem_rdata;
        case (funct3_q)
            3'b000:  load_data = {{(BIT_W-8){rsp_shift[7]}}, rsp_shift[7:0]};
            3'b001:  load_data = {{(BIT_W-16){rsp_shift[15]}}, rsp_shift[15:0]};
            3'b100:  load_data = {{(BIT_W-8){1'b0}}, rsp_shift[7:0]};
            3'b101:  load_data = {{(BIT_W-16){1'b0}}, rsp_shift[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ready_o       <= 1'b1;
            valid_o       <= 1'b0;
            misalign_o    <= 1'b0;
            pc_o          <= '0;
            inst_o        <= '0;
            ebreak_o      <= 1'b0;
            rd_o          <= '0;
            wb_data_o     <= '0;
            mem_req_valid <= 1'b0;
            mem_req_wen   <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            addr_lo       <= '0;
            funct3_q      <= '0;
            is_load       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ready_o    <= 1'b0;
                        pc_o       <= pc;
                        inst_o     <= inst;
                        ebreak_o   <= ebreak;
                        rd_o       <= rd;
                        addr_lo    <= alu_res[1:0];
                        funct3_q   <= funct3;
                        is_load    <= mem_ren & ~mem_wen;
                        misalign_o <= 1'b0;
                        if (!acc_mem) begin
                            wb_data_o <= alu_res;
                            valid_o   <= 1'b1;
                            state     <= DONE;
                        end else if (acc_illegal) begin
                            wb_data_o  <= '0;
                            misalign_o <= 1'b1;
                            valid_o    <= 1'b1;
                            state      <= DONE;
                        end else begin
                            mem_req_valid <= 1'b1;
                            mem_req_wen   <= mem_wen;
                            mem_addr      <= {alu_res[BIT_W-1:2], 2'b00};
                            mem_wdata     <= mem_wen ? acc_wdata : '0;
                            mem_wstrb     <= acc_strb;
                            state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        wb_data_o <= is_load ? load_data : '0;
                        valid_o   <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (next_ready) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_lsu.sv
// tb_ysyx_lsu - directed testbench for ysyx_lsu. Inputs are driven and
// outputs sampled on the falling edge of clk.

module tb_ysyx_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, inst, alu_res, wdata;
    logic        ebreak;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        mem_ren, mem_wen, prev_valid;
    logic        ready_o;
    logic [31:0] pc_o, inst_o, wb_data_o;
    logic        ebreak_o;
    logic [4:0]  rd_o;
    logic        misalign_o, valid_o, next_ready;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ysyx_lsu #(.BIT_W(32)) dut (
        .clk(clk), .rst(rst),
        .pc(pc), .inst(inst), .ebreak(ebreak), .rd(rd),
        .alu_res(alu_res), .wdata(wdata), .funct3(funct3),
        .mem_ren(mem_ren), .mem_wen(mem_wen),
        .prev_valid(prev_valid), .ready_o(ready_o),
        .pc_o(pc_o), .inst_o(inst_o), .ebreak_o(ebreak_o), .rd_o(rd_o),
        .wb_data_o(wb_data_o), .misalign_o(misalign_o),
        .valid_o(valid_o), .next_ready(next_ready),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one payload for exactly one rising edge (DUT is in IDLE).
    task automatic issue(input logic ren, input logic wen, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        check("ready_before_accept", {31'b0, ready_o}, 32'd1);
        pc         = 32'h8000_0100 + a;
        inst       = 32'h0000_0013 ^ a;
        ebreak     = 1'b0;
        rd         = 5'd7;
        mem_ren    = ren;
        mem_wen    = wen;
        funct3     = f3;
        alu_res    = a;
        wdata      = wd;
        prev_valid = 1'b1;
        @(negedge clk);
        prev_valid = 1'b0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
    endtask

    // Complete the DONE handshake and confirm return to IDLE.
    task automatic finish_op(input string tag);
        next_ready = 1'b1;
        @(negedge clk);
        next_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'b0, valid_o}, 32'd0);
        check({tag, "_ready_back"}, {31'b0, ready_o}, 32'd1);
    endtask

    // Legal memory access: request stalled for 'stall' cycles, then response.
    task automatic mem_op(input string tag, input logic ren, input logic wen,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdata, input int stall,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wb);
        issue(ren, wen, f3, a, wd);
        for (int i = 0; i <= stall; i++) begin
            check({tag, "_req_valid"}, {31'b0, mem_req_valid}, 32'd1);
            check({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
            check({tag, "_wen"}, {31'b0, mem_req_wen}, {31'b0, wen});
            if (wen) begin
                check({tag, "_wdata"}, mem_wdata, exp_wdata);
                check({tag, "_wstrb"}, {28'b0, mem_wstrb}, {28'b0, exp_strb});
            end
            if (i < stall) @(negedge clk);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check({tag, "_req_drop"}, {31'b0, mem_req_valid}, 32'd0);
        check({tag, "_wait_valid"}, {31'b0, valid_o}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rdata     = rdata;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'hDEAD_BEEF;
        check({tag, "_valid"}, {31'b0, valid_o}, 32'd1);
        check({tag, "_wb"}, wb_data_o, exp_wb);
        check({tag, "_misalign"}, {31'b0, misalign_o}, 32'd0);
        check({tag, "_pc"}, pc_o, 32'h8000_0100 + a);
        finish_op(tag);
    endtask

    // Illegal access: straight to DONE with misalign_o set.
    task automatic bad_op(input string tag, input logic ren, input logic wen,
                          input logic [2:0] f3, input logic [31:0] a);
        issue(ren, wen, f3, a, 32'h1234_5678);
        check({tag, "_no_req"}, {31'b0, mem_req_valid}, 32'd0);
        check({tag, "_valid"}, {31'b0, valid_o}, 32'd1);
        check({tag, "_misalign"}, {31'b0, misalign_o}, 32'd1);
        check({tag, "_wb"}, wb_data_o, 32'd0);
        finish_op(tag);
    endtask

    initial begin
        rst = 1'b1;
        pc = '0; inst = '0; ebreak = 1'b0; rd = '0; alu_res = '0; wdata = '0;
        funct3 = '0; mem_ren = 1'b0; mem_wen = 1'b0; prev_valid = 1'b0;
        next_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_ready", {31'b0, ready_o}, 32'd1);
        check("rst_valid", {31'b0, valid_o}, 32'd0);
        check("rst_req", {31'b0, mem_req_valid}, 32'd0);
        check("rst_misalign", {31'b0, misalign_o}, 32'd0);
        check("rst_wb", wb_data_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);

        // Non-memory pass-through, next_ready already high.
        next_ready = 1'b1;
        issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0);
        check("alu_valid", {31'b0, valid_o}, 32'd1);
        check("alu_wb", wb_data_o, 32'h0000_1234);
        check("alu_ready_low", {31'b0, ready_o}, 32'd0);
        check("alu_no_req", {31'b0, mem_req_valid}, 32'd0);
        check("alu_rd", {27'b0, rd_o}, 32'd7);
        @(negedge clk);
        next_ready = 1'b0;
        check("alu_valid_drop", {31'b0, valid_o}, 32'd0);
        check("alu_ready_back", {31'b0, ready_o}, 32'd1);

        // Loads.
        mem_op("lb",  1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80AA_5511, 0, 32'h0, 4'h0, 32'hFFFF_FF80);
        mem_op("lbu", 1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80AA_5511, 0, 32'h0, 4'h0, 32'h0000_0080);
        mem_op("lhu", 1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h80AA_5511, 1, 32'h0, 4'h0, 32'h0000_80AA);
        mem_op("lh",  1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h80AA_5511, 0, 32'h0, 4'h0, 32'hFFFF_80AA);
        mem_op("lb1", 1'b1, 1'b0, 3'b000, 32'h8000_0001, 32'h0, 32'h80AA_5511, 0, 32'h0, 4'h0, 32'h0000_0055);
        mem_op("lw",  1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'h80AA_5511, 0, 32'h0, 4'h0, 32'h80AA_5511);

        // Stores, SH with the request stalled three cycles.
        mem_op("sh", 1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'h0, 3, 32'hBEEF_0000, 4'b1100, 32'h0);
        mem_op("sb", 1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 32'h0, 0, 32'h0000_AB00, 4'b0010, 32'h0);
        mem_op("sw", 1'b0, 1'b1, 3'b010, 32'h8000_0008, 32'h1122_3344, 32'h0, 0, 32'h1122_3344, 4'b1111, 32'h0);

        // Illegal / misaligned accesses.
        bad_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h8000_0001);
        bad_op("sh_mis", 1'b0, 1'b1, 3'b001, 32'h8000_0003);
        bad_op("ld_f3",  1'b1, 1'b0, 3'b011, 32'h8000_0000);
        bad_op("rw_both", 1'b1, 1'b1, 3'b010, 32'h8000_0000);

        // Backpressure: DONE held 5 cycles; also misalign cleared on this accept.
        issue(1'b0, 1'b0, 3'b000, 32'hCAFE_0001, 32'h0);
        check("bp_misalign_clr", {31'b0, misalign_o}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'b0, valid_o}, 32'd1);
            check("bp_wb", wb_data_o, 32'hCAFE_0001);
            check("bp_ready", {31'b0, ready_o}, 32'd0);
            check("bp_pc", pc_o, 32'h8000_0100 + 32'hCAFE_0001);
            if (i < 4) @(negedge clk);
        end
        finish_op("bp");

        // Reset while waiting for a response, then a late response in IDLE.
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0);
        check("rw_req_valid", {31'b0, mem_req_valid}, 32'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rw_ready", {31'b0, ready_o}, 32'd1);
        check("rw_req", {31'b0, mem_req_valid}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h5555_AAAA;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("late_valid", {31'b0, valid_o}, 32'd0);
        check("late_wb", wb_data_o, 32'd0);
        check("late_ready", {31'b0, ready_o}, 32'd1);
        @(negedge clk);
        check("late_valid2", {31'b0, valid_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
